// File: rtl/ecc_pkg.sv
// Shared ECC datapath types: coordinate width and the PointAdd arbiter FSM states.
package ecc_pkg;

  localparam int W = 255;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} padd_arb_state_t;

  typedef logic [W-1:0] coord_t;

endpackage

// File: rtl/padd_arb_pick.sv
// Combinational grant selection over the registered pending vector.
// PADD_ARB_RR_EN selects round-robin from rr_ptr_i+1; otherwise the lowest index wins.
module padd_arb_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic [IW-1:0]    grant_o,
  output logic             any_o
);

  assign any_o = |pending_i;

`ifdef PADD_ARB_RR_EN
  int best;
  int dist;

  // Distance 0 is the slot right after the last served one.
  always_comb begin
    grant_o = '0;
    best    = N_REQ;
    dist    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      dist = (i + N_REQ - 1 - int'(rr_ptr_i)) % N_REQ;
      if (pending_i[i] && (dist < best)) begin
        best    = dist;
        grant_o = IW'(i);
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^rr_ptr_i;

  always_comb begin
    grant_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending_i[i]) grant_o = IW'(i);
    end
  end
`endif

endmodule

// File: rtl/padd_arbiter.sv
// Shares one PointAdd core between N_REQ requesters: per-slot operand capture,
// IDLE/ISSUE/WAIT sequencing and result return. Macro PADD_ARB_RR_EN enables round-robin.
module padd_arbiter #(
  parameter int N_REQ = 2,
  parameter int W     = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_start,
  input  logic [N_REQ*W-1:0] i_x1,
  input  logic [N_REQ*W-1:0] i_y1,
  input  logic [N_REQ*W-1:0] i_z1,
  input  logic [N_REQ*W-1:0] i_x2,
  input  logic [N_REQ*W-1:0] i_y2,
  input  logic [N_REQ*W-1:0] i_z2,
  output logic [N_REQ-1:0]   o_finished,
  output logic [W-1:0]       o_x3,
  output logic [W-1:0]       o_y3,
  output logic [W-1:0]       o_z3,
  output logic [N_REQ-1:0]   o_pending,
  output logic               o_busy,
  output logic               o_pa_start,
  output logic [W-1:0]       o_pa_x1,
  output logic [W-1:0]       o_pa_y1,
  output logic [W-1:0]       o_pa_z1,
  output logic [W-1:0]       o_pa_x2,
  output logic [W-1:0]       o_pa_y2,
  output logic [W-1:0]       o_pa_z2,
  input  logic [W-1:0]       i_pa_x3,
  input  logic [W-1:0]       i_pa_y3,
  input  logic [W-1:0]       i_pa_z3,
  input  logic               i_pa_finished
);

  import ecc_pkg::*;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  padd_arb_state_t  state_q;
  logic [IW-1:0]    grant_q;
  logic [IW-1:0]    rr_ptr;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] finished_q;
  logic             pa_start_q;
  logic [W-1:0]     x3_q, y3_q, z3_q;
  logic [W-1:0]     x1_q [N_REQ];
  logic [W-1:0]     y1_q [N_REQ];
  logic [W-1:0]     z1_q [N_REQ];
  logic [W-1:0]     x2_q [N_REQ];
  logic [W-1:0]     y2_q [N_REQ];
  logic [W-1:0]     z2_q [N_REQ];
  logic [IW-1:0]    pick_grant;
  logic             pick_any;
  logic             done;

  assign done = (state_q == WAIT) && i_pa_finished;

`ifdef PADD_ARB_RR_EN
  logic [IW-1:0] rr_ptr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q <= IW'(N_REQ - 1);
    end else if (done) begin
      rr_ptr_q <= grant_q;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  padd_arb_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .pending_i (pending_q),
    .rr_ptr_i  (rr_ptr),
    .grant_o   (pick_grant),
    .any_o     (pick_any)
  );

  // A slot only accepts a start while empty, so its operands stay frozen until served.
  always_comb begin
    pending_d = pending_q;
    if (done) pending_d[grant_q] = 1'b0;
    for (int n = 0; n < N_REQ; n++) begin
      if (i_start[n] && !pending_q[n]) pending_d[n] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int n = 0; n < N_REQ; n++) begin
        x1_q[n] <= '0;
        y1_q[n] <= '0;
        z1_q[n] <= '0;
        x2_q[n] <= '0;
        y2_q[n] <= '0;
        z2_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < N_REQ; n++) begin
        if (i_start[n] && !pending_q[n]) begin
          x1_q[n] <= i_x1[n*W +: W];
          y1_q[n] <= i_y1[n*W +: W];
          z1_q[n] <= i_z1[n*W +: W];
          x2_q[n] <= i_x2[n*W +: W];
          y2_q[n] <= i_y2[n*W +: W];
          z2_q[n] <= i_z2[n*W +: W];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      pending_q  <= '0;
      finished_q <= '0;
      pa_start_q <= 1'b0;
      x3_q       <= '0;
      y3_q       <= '0;
      z3_q       <= '0;
    end else begin
      pending_q  <= pending_d;
      finished_q <= '0;
      pa_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_grant;
            pa_start_q <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (i_pa_finished) begin
            x3_q                <= i_pa_x3;
            y3_q                <= i_pa_y3;
            z3_q                <= i_pa_z3;
            finished_q[grant_q] <= 1'b1;
            state_q             <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_finished = finished_q;
  assign o_x3       = x3_q;
  assign o_y3       = y3_q;
  assign o_z3       = z3_q;
  assign o_pending  = pending_q;
  assign o_busy     = (state_q != IDLE) || (|pending_q);
  assign o_pa_start = pa_start_q;
  assign o_pa_x1    = x1_q[grant_q];
  assign o_pa_y1    = y1_q[grant_q];
  assign o_pa_z1    = z1_q[grant_q];
  assign o_pa_x2    = x2_q[grant_q];
  assign o_pa_y2    = y2_q[grant_q];
  assign o_pa_z2    = z2_q[grant_q];

endmodule
